freq_gen: RTL and testbench

FREQ_GEN -- requirements
Module: freq_gen

---
 rtl/freq_gen_pkg.sv | 8 +
 rtl/freq_gen_cfg.sv | 77 +++++++
 rtl/freq_gen.sv | 117 +++++++++++
 tb/tb_freq_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the frequency generator.
package freq_gen_pkg;
  localparam int          CNT_W          = 32;
  localparam logic [31:0] DEFAULT_PERIOD = 32'd48;
  localparam int          MIN_PERIOD     = 2;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
endpackage

// File: rtl/freq_gen_cfg.sv
// Configuration handshake, validation and single-entry shadow register.
// FREQ_GEN_DUTY_EN adds a programmable high time next to the period.
module freq_gen_cfg #(
  parameter int CNT_W = freq_gen_pkg::CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
`ifdef FREQ_GEN_DUTY_EN
  input  logic [CNT_W-1:0] cfg_high,
  output logic [CNT_W-1:0] sh_high,
`endif
  input  logic             apply,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             pend,
  output logic [CNT_W-1:0] sh_period
);
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             bad;
`ifdef FREQ_GEN_DUTY_EN
  logic [CNT_W-1:0] hi_q, hi_d;
  assign bad = (cfg_period < CNT_W'(freq_gen_pkg::MIN_PERIOD)) ||
               (cfg_high == '0) || (cfg_high >= cfg_period);
  assign sh_high = hi_q;
`else
  assign bad = (cfg_period < CNT_W'(freq_gen_pkg::MIN_PERIOD));
`endif

  // Ready is simply "shadow empty": drops after accept, rises after apply.
  assign cfg_ready = ~pend_q;
  assign cfg_err   = err_q;
  assign pend      = pend_q;
  assign sh_period = per_q;

  always_comb begin
    pend_d = pend_q;
    per_d  = per_q;
    err_d  = 1'b0;
`ifdef FREQ_GEN_DUTY_EN
    hi_d   = hi_q;
`endif
    if (apply) pend_d = 1'b0;
    if (cfg_valid && !pend_q) begin
      if (bad) begin
        err_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        per_d  = cfg_period;
`ifdef FREQ_GEN_DUTY_EN
        hi_d   = cfg_high;
`endif
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      per_q  <= '0;
`ifdef FREQ_GEN_DUTY_EN
      hi_q   <= '0;
`endif
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
      per_q  <= per_d;
`ifdef FREQ_GEN_DUTY_EN
      hi_q   <= hi_d;
`endif
    end
  end
endmodule

// File: rtl/freq_gen.sv
// Square-wave generator: IDLE/HIGH/LOW phase counter with shadowed reconfig.
// FREQ_GEN_DUTY_EN enables a programmable high time (cfg_high).
module freq_gen #(
  parameter int             CNT_W          = freq_gen_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(freq_gen_pkg::DEFAULT_PERIOD)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
`ifdef FREQ_GEN_DUTY_EN
  input  logic [CNT_W-1:0] cfg_high,
`endif
  output logic             cfg_err,
  output logic             sig_out,
  output logic             active,
  output logic [31:0]      edge_cnt
);
  import freq_gen_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [31:0]      edge_q, edge_d;
  logic             sig_q;
  logic             pend, apply;
  logic [CNT_W-1:0] sh_period, h_eff, l_eff;

`ifdef FREQ_GEN_DUTY_EN
  logic [CNT_W-1:0] sh_high, hi_q, hi_d;
  assign hi_d  = apply ? sh_high : hi_q;
  assign h_eff = hi_d;
`else
  assign h_eff = per_d >> 1;
`endif
  assign l_eff = per_d - h_eff;

  freq_gen_cfg #(.CNT_W(CNT_W)) u_cfg (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_valid (cfg_valid),
    .cfg_period(cfg_period),
`ifdef FREQ_GEN_DUTY_EN
    .cfg_high  (cfg_high),
    .sh_high   (sh_high),
`endif
    .apply     (apply),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .pend      (pend),
    .sh_period (sh_period)
  );

  // Shadow lands in IDLE right away, or at the LOW->HIGH boundary while running.
  assign apply = pend && ((state_q == IDLE) ||
                          (state_q == LOW && cnt_q == '0 && run_en));
  assign per_d = apply ? sh_period : per_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    case (state_q)
      IDLE: if (run_en) begin
        state_d = HIGH;
        cnt_d   = h_eff - CNT_W'(1);
        edge_d  = 32'd1;
      end
      HIGH: if (cnt_q == '0) begin
        state_d = LOW;
        cnt_d   = l_eff - CNT_W'(1);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      LOW: if (cnt_q == '0) begin
        if (run_en) begin
          state_d = HIGH;
          cnt_d   = h_eff - CNT_W'(1);
          edge_d  = edge_q + 32'd1;
        end else begin
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= DEFAULT_PERIOD;
      edge_q  <= '0;
      sig_q   <= 1'b0;
`ifdef FREQ_GEN_DUTY_EN
      hi_q    <= DEFAULT_PERIOD >> 1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      edge_q  <= edge_d;
      sig_q   <= (state_d == HIGH);
`ifdef FREQ_GEN_DUTY_EN
      hi_q    <= hi_d;
`endif
    end
  end

  assign sig_out  = sig_q;
  assign active   = (state_q != IDLE);
  assign edge_cnt = edge_q;
endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen; optional duty scenario under FREQ_GEN_DUTY_EN.
module tb_freq_gen;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_period = '0;
`ifdef FREQ_GEN_DUTY_EN
  logic [31:0] cfg_high = '0;
`endif
  logic        cfg_ready, cfg_err, sig_out, active;
  logic [31:0] edge_cnt;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  freq_gen dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run_en    (run_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
`ifdef FREQ_GEN_DUTY_EN
    .cfg_high  (cfg_high),
`endif
    .cfg_err   (cfg_err),
    .sig_out   (sig_out),
    .active    (active),
    .edge_cnt  (edge_cnt)
  );

  task automatic tick;
    @(posedge sys_clk); #1;
  endtask

  task automatic do_reset;
    run_en = 0; cfg_valid = 0;
    sys_rst_n = 0;
    tick; tick;
    sys_rst_n = 1;
    tick;
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      prev = sig_out;
      tick;
      if (prev === 1'b0 && sig_out === 1'b1) ok = 1;
    end
  endtask

  task automatic count_while(input logic lvl, output int n);
    n = 0;
    while (sig_out === lvl && n < 1000) begin n++; tick; end
  endtask

  task automatic measure(output int hi, output int lo);
    bit ok;
    wait_rise(ok);
    if (!ok) begin hi = -1; lo = -1; end
    else begin count_while(1'b1, hi); count_while(1'b0, lo); end
  endtask

  task automatic test_reset;
    sys_rst_n = 0; #1;
    checks++;
    if (sig_out !== 0 || active !== 0 || cfg_ready !== 1 || cfg_err !== 0 || edge_cnt !== 0) begin
      failures++;
      $display("FAIL reset_state: sig=%b act=%b rdy=%b err=%b edges=%0d, want 0 0 1 0 0",
               sig_out, active, cfg_ready, cfg_err, edge_cnt);
    end
    do_reset;
  endtask

  task automatic test_default;
    int hi, lo;
    do_reset;
    run_en = 1;
    tick;
    checks++;
    if (sig_out !== 1 || edge_cnt !== 1 || active !== 1) begin
      failures++;
      $display("FAIL start: sig=%b edges=%0d act=%b, want 1 1 1", sig_out, edge_cnt, active);
    end
    repeat (479) tick;
    checks++;
    if (edge_cnt !== 10) begin
      failures++; $display("FAIL edges_480: got %0d want 10", edge_cnt);
    end
    measure(hi, lo);
    checks++;
    if (hi !== 24 || lo !== 24) begin
      failures++; $display("FAIL default_wave: got %0d/%0d want 24/24", hi, lo);
    end
  endtask

  task automatic test_cfg_idle;
    int hi, lo;
    do_reset;
    cfg_period = 10; cfg_valid = 1;
    tick;
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 0) begin failures++; $display("FAIL ready_drop: got %b want 0", cfg_ready); end
    tick;
    checks++;
    if (cfg_ready !== 1) begin failures++; $display("FAIL ready_rise_idle: got %b want 1", cfg_ready); end
    run_en = 1;
    measure(hi, lo);
    checks++;
    if (hi !== 5 || lo !== 5) begin failures++; $display("FAIL p10_wave: got %0d/%0d want 5/5", hi, lo); end
    cfg_period = 7; cfg_valid = 1;
    tick;
    cfg_valid = 0;
    measure(hi, lo);
    measure(hi, lo);
    checks++;
    if (hi !== 3 || lo !== 4) begin failures++; $display("FAIL p7_wave: got %0d/%0d want 3/4", hi, lo); end
  endtask

  task automatic test_reject;
    int hi, lo;
    do_reset;
    run_en = 1;
    repeat (4) tick;
    cfg_period = 1; cfg_valid = 1;
    tick;
    cfg_valid = 0;
    checks++;
    if (cfg_err !== 1 || cfg_ready !== 1) begin
      failures++; $display("FAIL reject_pulse: err=%b rdy=%b want 1 1", cfg_err, cfg_ready);
    end
    tick;
    checks++;
    if (cfg_err !== 0 || cfg_ready !== 1) begin
      failures++; $display("FAIL reject_after: err=%b rdy=%b want 0 1", cfg_err, cfg_ready);
    end
    measure(hi, lo);
    checks++;
    if (hi !== 24 || lo !== 24) begin failures++; $display("FAIL reject_wave: got %0d/%0d want 24/24", hi, lo); end
  endtask

  task automatic test_mid_high;
    int hi, lo;
    bit rdy_bad;
    do_reset;
    run_en = 1;
    tick;
    hi = 0;
    cfg_period = 20;
    while (sig_out === 1'b1 && hi < 1000) begin
      cfg_valid = (hi == 5);
      hi++; tick;
    end
    cfg_valid = 0;
    lo = 0; rdy_bad = 0;
    while (sig_out === 1'b0 && lo < 1000) begin
      if (cfg_ready !== 1'b0) rdy_bad = 1;
      lo++; tick;
    end
    checks++;
    if (hi !== 24 || lo !== 24) begin failures++; $display("FAIL mid_cur_wave: got %0d/%0d want 24/24", hi, lo); end
    checks++;
    if (rdy_bad !== 0) begin failures++; $display("FAIL mid_ready_low: ready rose before boundary, want low"); end
    checks++;
    if (cfg_ready !== 1) begin failures++; $display("FAIL mid_ready_rise: got %b want 1", cfg_ready); end
    count_while(1'b1, hi);
    count_while(1'b0, lo);
    checks++;
    if (hi !== 10 || lo !== 10) begin failures++; $display("FAIL mid_new_wave: got %0d/%0d want 10/10", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int hi, lo;
    do_reset;
    run_en = 1;
    repeat (10) tick;
    run_en = 0;
    count_while(1'b1, hi);
    checks++;
    if (hi !== 15) begin failures++; $display("FAIL drop_rest_high: got %0d want 15", hi); end
    repeat (10) tick;
    run_en = 1;
    count_while(1'b0, lo);
    checks++;
    if (lo !== 14 || edge_cnt !== 2) begin
      failures++; $display("FAIL resume_gap: low %0d edges %0d want 14 2", lo, edge_cnt);
    end
    run_en = 0;
    count_while(1'b1, hi);
    lo = 0;
    while (active === 1'b1 && lo < 1000) begin lo++; tick; end
    checks++;
    if (hi !== 24 || lo !== 24) begin failures++; $display("FAIL stop_wave: got %0d/%0d want 24/24", hi, lo); end
    repeat (60) tick;
    checks++;
    if (sig_out !== 0 || active !== 0 || edge_cnt !== 2) begin
      failures++; $display("FAIL idle_hold: sig=%b act=%b edges=%0d want 0 0 2", sig_out, active, edge_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int hi, lo;
    do_reset;
    run_en = 1;
    repeat (5) tick;
    cfg_period = 20; cfg_valid = 1;
    tick;
    cfg_valid = 0;
    sys_rst_n = 0; #1;
    checks++;
    if (sig_out !== 0 || active !== 0 || edge_cnt !== 0 || cfg_ready !== 1) begin
      failures++; $display("FAIL reset_mid: sig=%b act=%b edges=%0d rdy=%b want 0 0 0 1",
                           sig_out, active, edge_cnt, cfg_ready);
    end
    tick;
    sys_rst_n = 1;
    tick;
    measure(hi, lo);
    checks++;
    if (hi !== 24 || lo !== 24) begin failures++; $display("FAIL reset_shadow: got %0d/%0d want 24/24", hi, lo); end
  endtask

`ifdef FREQ_GEN_DUTY_EN
  task automatic test_duty;
    int hi, lo;
    do_reset;
    cfg_period = 10; cfg_high = 3; cfg_valid = 1;
    tick;
    cfg_valid = 0;
    tick;
    run_en = 1;
    measure(hi, lo);
    checks++;
    if (hi !== 3 || lo !== 7) begin failures++; $display("FAIL duty_wave: got %0d/%0d want 3/7", hi, lo); end
    do_reset;
    cfg_period = 10; cfg_high = 10; cfg_valid = 1;
    tick;
    cfg_valid = 0;
    checks++;
    if (cfg_err !== 1 || cfg_ready !== 1) begin
      failures++; $display("FAIL duty_reject: err=%b rdy=%b want 1 1", cfg_err, cfg_ready);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_default;
    test_cfg_idle;
    test_reject;
    test_mid_high;
    test_back_to_back;
    test_reset_mid;
`ifdef FREQ_GEN_DUTY_EN
    test_duty;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
